// File: rtl/microwatt_wb_mailbox_if.sv
// Bus bundle for the mailbox: 32-bit classic Wishbone from the SoC (wbs_*) and the Microwatt
// 64-bit pipelined Wishbone port (uw_*). Suffixes are from the mailbox's point of view.
interface microwatt_wb_mailbox_if;
   logic        wbs_cyc_i;
   logic        wbs_stb_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i;
   logic [31:0] wbs_dat_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;

   logic        uw_cyc_i;
   logic        uw_stb_i;
   logic        uw_we_i;
   logic [7:0]  uw_sel_i;
   logic [31:0] uw_adr_i;
   logic [63:0] uw_dat_i;
   logic [63:0] uw_dat_o;
   logic        uw_ack_o;
   logic        uw_stall_o;

   modport slave (
      input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      output wbs_ack_o, wbs_dat_o,
      input  uw_cyc_i, uw_stb_i, uw_we_i, uw_sel_i, uw_adr_i, uw_dat_i,
      output uw_dat_o, uw_ack_o, uw_stall_o
   );

   modport master (
      output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      input  wbs_ack_o, wbs_dat_o,
      output uw_cyc_i, uw_stb_i, uw_we_i, uw_sel_i, uw_adr_i, uw_dat_i,
      input  uw_dat_o, uw_ack_o, uw_stall_o
   );
endinterface

// File: rtl/microwatt_wb_mailbox.sv
// Bidirectional mailbox between the Caravel SoC (wbs) and Microwatt (uw): two 32-bit FIFOs,
// M2S and S2M, each side with a DATA/STATUS word pair and a level interrupt on receive data.
module microwatt_wb_mailbox #(
   parameter int unsigned DEPTH     = 8,
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
   input  logic                  ext_clk,
   input  logic                  ext_rst,
   microwatt_wb_mailbox_if.slave bus_io,
   output logic                  soc_irq_o,
   output logic                  uw_irq_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef logic [AW-1:0] ptr_t;
   typedef logic [CW-1:0] cnt_t;

   logic [31:0] m2s_mem_q [DEPTH];
   logic [31:0] s2m_mem_q [DEPTH];
   ptr_t        m2s_wr_q, m2s_wr_d, m2s_rd_q, m2s_rd_d;
   ptr_t        s2m_wr_q, s2m_wr_d, s2m_rd_q, s2m_rd_d;
   cnt_t        m2s_cnt_q, m2s_cnt_d, s2m_cnt_q, s2m_cnt_d;
   logic        soc_unf_q, soc_unf_d, soc_ovf_q, soc_ovf_d, soc_ien_q, soc_ien_d;
   logic        uw_unf_q, uw_unf_d, uw_ovf_q, uw_ovf_d, uw_ien_q, uw_ien_d;
   logic        soc_ack_q, soc_ack_d, uw_ack_q, uw_ack_d;
   logic [31:0] soc_dat_q, soc_dat_d, uw_dat_q, uw_dat_d;
   logic        soc_irq_q, soc_irq_d, uw_irq_q, uw_irq_d;

   logic [1:0]  soc_word, uw_word;
   logic        soc_hit, soc_acc, soc_wr, soc_push, soc_pop, soc_st_wr;
   logic        uw_acc, uw_wr, uw_push, uw_pop, uw_st_wr;
   logic        m2s_full, m2s_empty, s2m_full, s2m_empty;
   logic        m2s_do_push, m2s_do_pop, s2m_do_push, s2m_do_pop;
   logic [31:0] m2s_head, s2m_head, soc_rdata, uw_rdata;
   logic        unused_bits;

   function automatic logic [31:0] status_word(input cnt_t rx_cnt, input cnt_t tx_cnt,
                                               input logic rx_unf, input logic tx_ovf,
                                               input logic ien);
      logic [31:0] s;
      s        = '0;
      s[0]     = rx_cnt != '0;
      s[1]     = tx_cnt == FULL;
      s[2]     = rx_unf;
      s[3]     = tx_ovf;
      s[15:8]  = 8'(rx_cnt);
      s[23:16] = 8'(tx_cnt);
      s[31]    = ien;
      return s;
   endfunction

   always_comb begin
      soc_word  = bus_io.wbs_adr_i[3:2];
      soc_hit   = bus_io.wbs_adr_i[31:4] == BASE_ADDR[31:4];
      soc_acc   = bus_io.wbs_cyc_i & bus_io.wbs_stb_i & soc_hit & ~soc_ack_q;
      soc_wr    = soc_acc & bus_io.wbs_we_i;
      soc_push  = soc_wr & (soc_word == 2'd0) & (|bus_io.wbs_sel_i);
      soc_pop   = soc_acc & ~bus_io.wbs_we_i & (soc_word == 2'd0);
      soc_st_wr = soc_wr & (soc_word == 2'd1);

      uw_word   = bus_io.uw_adr_i[4:3];
      uw_acc    = bus_io.uw_cyc_i & bus_io.uw_stb_i;
      uw_wr     = uw_acc & bus_io.uw_we_i;
      uw_push   = uw_wr & (uw_word == 2'd0) & (|bus_io.uw_sel_i[3:0]);
      uw_pop    = uw_acc & ~bus_io.uw_we_i & (uw_word == 2'd0);
      uw_st_wr  = uw_wr & (uw_word == 2'd1);
   end

   // Full/empty come from pre-edge state: a same-cycle pop never makes room for a push,
   // and a same-cycle push never feeds an empty pop.
   always_comb begin
      m2s_full    = m2s_cnt_q == FULL;
      m2s_empty   = m2s_cnt_q == '0;
      s2m_full    = s2m_cnt_q == FULL;
      s2m_empty   = s2m_cnt_q == '0;
      m2s_do_push = uw_push & ~m2s_full;
      m2s_do_pop  = soc_pop & ~m2s_empty;
      s2m_do_push = soc_push & ~s2m_full;
      s2m_do_pop  = uw_pop & ~s2m_empty;

      m2s_wr_d  = m2s_do_push ? m2s_wr_q + 1'b1 : m2s_wr_q;
      m2s_rd_d  = m2s_do_pop  ? m2s_rd_q + 1'b1 : m2s_rd_q;
      s2m_wr_d  = s2m_do_push ? s2m_wr_q + 1'b1 : s2m_wr_q;
      s2m_rd_d  = s2m_do_pop  ? s2m_rd_q + 1'b1 : s2m_rd_q;
      m2s_cnt_d = m2s_cnt_q + cnt_t'(m2s_do_push) - cnt_t'(m2s_do_pop);
      s2m_cnt_d = s2m_cnt_q + cnt_t'(s2m_do_push) - cnt_t'(s2m_do_pop);

      // Sticky set takes priority over a same-cycle write-1-to-clear.
      soc_unf_d = (soc_unf_q & ~(soc_st_wr & bus_io.wbs_dat_i[2])) | (soc_pop & m2s_empty);
      soc_ovf_d = (soc_ovf_q & ~(soc_st_wr & bus_io.wbs_dat_i[3])) | (soc_push & s2m_full);
      soc_ien_d = soc_st_wr ? bus_io.wbs_dat_i[31] : soc_ien_q;
      uw_unf_d  = (uw_unf_q & ~(uw_st_wr & bus_io.uw_dat_i[2])) | (uw_pop & s2m_empty);
      uw_ovf_d  = (uw_ovf_q & ~(uw_st_wr & bus_io.uw_dat_i[3])) | (uw_push & m2s_full);
      uw_ien_d  = uw_st_wr ? bus_io.uw_dat_i[31] : uw_ien_q;

      soc_irq_d = (m2s_cnt_d != '0) & soc_ien_d;
      uw_irq_d  = (s2m_cnt_d != '0) & uw_ien_d;
   end

   always_comb begin
      m2s_head = m2s_empty ? '0 : m2s_mem_q[m2s_rd_q];
      s2m_head = s2m_empty ? '0 : s2m_mem_q[s2m_rd_q];

      unique case (soc_word)
         2'd0:    soc_rdata = m2s_head;
         2'd1:    soc_rdata = status_word(m2s_cnt_q, s2m_cnt_q, soc_unf_q, soc_ovf_q, soc_ien_q);
         default: soc_rdata = '0;
      endcase
      unique case (uw_word)
         2'd0:    uw_rdata = s2m_head;
         2'd1:    uw_rdata = status_word(s2m_cnt_q, m2s_cnt_q, uw_unf_q, uw_ovf_q, uw_ien_q);
         default: uw_rdata = '0;
      endcase

      soc_ack_d = soc_acc;
      soc_dat_d = (soc_acc & ~bus_io.wbs_we_i) ? soc_rdata : '0;
      uw_ack_d  = uw_acc;
      uw_dat_d  = (uw_acc & ~bus_io.uw_we_i) ? uw_rdata : '0;
   end

   always_ff @(posedge ext_clk) begin
      if (m2s_do_push) m2s_mem_q[m2s_wr_q] <= bus_io.uw_dat_i[31:0];
      if (s2m_do_push) s2m_mem_q[s2m_wr_q] <= bus_io.wbs_dat_i;
   end

   always_ff @(posedge ext_clk or negedge ext_rst) begin
      if (!ext_rst) begin
         m2s_wr_q  <= '0;
         m2s_rd_q  <= '0;
         s2m_wr_q  <= '0;
         s2m_rd_q  <= '0;
         m2s_cnt_q <= '0;
         s2m_cnt_q <= '0;
         soc_unf_q <= 1'b0;
         soc_ovf_q <= 1'b0;
         soc_ien_q <= 1'b0;
         uw_unf_q  <= 1'b0;
         uw_ovf_q  <= 1'b0;
         uw_ien_q  <= 1'b0;
         soc_ack_q <= 1'b0;
         soc_dat_q <= '0;
         uw_ack_q  <= 1'b0;
         uw_dat_q  <= '0;
         soc_irq_q <= 1'b0;
         uw_irq_q  <= 1'b0;
      end else begin
         m2s_wr_q  <= m2s_wr_d;
         m2s_rd_q  <= m2s_rd_d;
         s2m_wr_q  <= s2m_wr_d;
         s2m_rd_q  <= s2m_rd_d;
         m2s_cnt_q <= m2s_cnt_d;
         s2m_cnt_q <= s2m_cnt_d;
         soc_unf_q <= soc_unf_d;
         soc_ovf_q <= soc_ovf_d;
         soc_ien_q <= soc_ien_d;
         uw_unf_q  <= uw_unf_d;
         uw_ovf_q  <= uw_ovf_d;
         uw_ien_q  <= uw_ien_d;
         soc_ack_q <= soc_ack_d;
         soc_dat_q <= soc_dat_d;
         uw_ack_q  <= uw_ack_d;
         uw_dat_q  <= uw_dat_d;
         soc_irq_q <= soc_irq_d;
         uw_irq_q  <= uw_irq_d;
      end
   end

   assign bus_io.wbs_ack_o  = soc_ack_q;
   assign bus_io.wbs_dat_o  = soc_dat_q;
   assign bus_io.uw_ack_o   = uw_ack_q;
   assign bus_io.uw_dat_o   = {32'h0, uw_dat_q};
   assign bus_io.uw_stall_o = ~ext_rst;
   assign soc_irq_o         = soc_irq_q;
   assign uw_irq_o          = uw_irq_q;

   assign unused_bits = ^{bus_io.wbs_adr_i[1:0], bus_io.uw_adr_i[31:5], bus_io.uw_adr_i[2:0],
                          bus_io.uw_sel_i[7:4], bus_io.uw_dat_i[63:32]};

endmodule

// File: tb/tb_microwatt_wb_mailbox.sv
// Self-checking bench for microwatt_wb_mailbox: directed vector table, hand-built corner
// sequences and random traffic compared against a queue-based model of both FIFOs.
module tb_microwatt_wb_mailbox;
   localparam int unsigned DEPTH = 8;
   localparam logic [31:0] BASE  = 32'h3000_0000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic soc_irq, uw_irq;

   microwatt_wb_mailbox_if bus ();

   microwatt_wb_mailbox #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
      .ext_clk  (clk),
      .ext_rst  (rst_n),
      .bus_io   (bus),
      .soc_irq_o(soc_irq),
      .uw_irq_o (uw_irq)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_fail = 0;

   // Model state; index 0 = SoC side, 1 = Microwatt side.
   logic [31:0] m2s_q[$];
   logic [31:0] s2m_q[$];
   bit          unf[2];
   bit          ovf[2];
   bit          ien[2];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   function automatic logic [31:0] model_status(input bit side);
      int rx_n = side ? s2m_q.size() : m2s_q.size();
      int tx_n = side ? m2s_q.size() : s2m_q.size();
      logic [31:0] s = '0;
      s[0]     = rx_n != 0;
      s[1]     = tx_n == int'(DEPTH);
      s[2]     = unf[side];
      s[3]     = ovf[side];
      s[15:8]  = 8'(rx_n);
      s[23:16] = 8'(tx_n);
      s[31]    = ien[side];
      return s;
   endfunction

   function automatic logic [31:0] model_xfer(input bit side, input bit we, input logic [1:0] word,
                                              input logic [31:0] wd, input logic [3:0] sel);
      logic [31:0] r = '0;
      if (word == 2'd0 && we && sel != 4'h0) begin
         if (side) begin
            if (m2s_q.size() == int'(DEPTH)) ovf[1] = 1'b1;
            else m2s_q.push_back(wd);
         end else begin
            if (s2m_q.size() == int'(DEPTH)) ovf[0] = 1'b1;
            else s2m_q.push_back(wd);
         end
      end else if (word == 2'd0 && !we) begin
         if (side) begin
            if (s2m_q.size() == 0) unf[1] = 1'b1;
            else r = s2m_q.pop_front();
         end else begin
            if (m2s_q.size() == 0) unf[0] = 1'b1;
            else r = m2s_q.pop_front();
         end
      end else if (word == 2'd1 && we) begin
         if (wd[2]) unf[side] = 1'b0;
         if (wd[3]) ovf[side] = 1'b0;
         ien[side] = wd[31];
      end else if (word == 2'd1) begin
         r = model_status(side);
      end
      return r;
   endfunction

   function automatic bit exp_soc_irq();
      return (m2s_q.size() != 0) && ien[0];
   endfunction

   function automatic bit exp_uw_irq();
      return (s2m_q.size() != 0) && ien[1];
   endfunction

   task automatic soc_xfer(input bit we, input logic [31:0] adr, input logic [31:0] wd,
                           input logic [3:0] sel, output logic [31:0] rd, output bit acked);
      bus.wbs_cyc_i = 1'b1;
      bus.wbs_stb_i = 1'b1;
      bus.wbs_we_i  = we;
      bus.wbs_adr_i = adr;
      bus.wbs_dat_i = wd;
      bus.wbs_sel_i = sel;
      acked = 1'b0;
      rd = '0;
      for (int i = 0; i < 4 && !acked; i++) begin
         @(posedge clk); #1;
         if (bus.wbs_ack_o) begin
            acked = 1'b1;
            rd = bus.wbs_dat_o;
         end
      end
      bus.wbs_cyc_i = 1'b0;
      bus.wbs_stb_i = 1'b0;
      bus.wbs_we_i  = 1'b0;
   endtask

   task automatic uw_xfer(input bit we, input logic [1:0] word, input logic [31:0] wd,
                          input logic [7:0] sel, output logic [63:0] rd, output bit acked);
      bus.uw_cyc_i = 1'b1;
      bus.uw_stb_i = 1'b1;
      bus.uw_we_i  = we;
      bus.uw_adr_i = {27'h0, word, 3'b000};
      bus.uw_dat_i = {32'hA5A5_5A5A, wd};
      bus.uw_sel_i = sel;
      @(posedge clk); #1;
      acked = bus.uw_ack_o;
      rd = bus.uw_dat_o;
      bus.uw_cyc_i = 1'b0;
      bus.uw_stb_i = 1'b0;
      bus.uw_we_i  = 1'b0;
   endtask

   task automatic do_op(input bit side, input bit we, input logic [1:0] word,
                        input logic [31:0] wd, input logic [3:0] sel,
                        output logic [63:0] rd, output logic [31:0] mexp);
      bit acked;
      logic [31:0] srd;
      if (side) begin
         uw_xfer(we, word, wd, {~sel, sel}, rd, acked);
         check("uw ack", acked, 1);
      end else begin
         soc_xfer(we, BASE | {28'h0, word, 2'b00}, wd, sel, srd, acked);
         rd = {32'h0, srd};
         check("soc ack", acked, 1);
      end
      mexp = model_xfer(side, we, word, wd, sel);
   endtask

   typedef struct {
      bit          side;
      bit          we;
      logic [1:0]  word;
      logic [31:0] wd;
      logic [63:0] exp_rd;
      bit          exp_soc_irq;
      bit          exp_uw_irq;
   } vec_t;

   vec_t        vecs[$];
   logic [63:0] rd;
   logic [31:0] mexp, srd;
   bit          acked, r_side, r_we;
   logic [1:0]  r_word;
   logic [3:0]  r_sel;
   logic [31:0] r_wd;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // side, we, word, wdata, expected read data, soc_irq, uw_irq
      vecs.push_back('{0, 1, 2'd0, 32'hDEAD_BEEF, 64'h0, 0, 0});
      vecs.push_back('{1, 0, 2'd0, 32'h0, 64'h0000_0000_DEAD_BEEF, 0, 0});
      vecs.push_back('{1, 0, 2'd1, 32'h0, 64'h0, 0, 0});
      vecs.push_back('{1, 0, 2'd0, 32'h0, 64'h0, 0, 0});
      vecs.push_back('{1, 0, 2'd1, 32'h0, 64'h4, 0, 0});
      vecs.push_back('{1, 1, 2'd1, 32'h4, 64'h0, 0, 0});
      vecs.push_back('{1, 0, 2'd1, 32'h0, 64'h0, 0, 0});
      vecs.push_back('{0, 0, 2'd0, 32'h0, 64'h0, 0, 0});
      vecs.push_back('{0, 0, 2'd1, 32'h0, 64'h4, 0, 0});
      vecs.push_back('{0, 1, 2'd1, 32'h8000_0004, 64'h0, 0, 0});
      vecs.push_back('{0, 0, 2'd1, 32'h0, 64'h8000_0000, 0, 0});
      vecs.push_back('{1, 1, 2'd0, 32'h5, 64'h0, 1, 0});
      vecs.push_back('{0, 0, 2'd1, 32'h0, 64'h8000_0101, 1, 0});
      vecs.push_back('{1, 0, 2'd1, 32'h0, 64'h0001_0000, 1, 0});
      vecs.push_back('{0, 0, 2'd0, 32'h0, 64'h5, 0, 0});
      vecs.push_back('{0, 0, 2'd2, 32'h0, 64'h0, 0, 0});
      vecs.push_back('{0, 1, 2'd3, 32'hFFFF_FFFF, 64'h0, 0, 0});
      vecs.push_back('{0, 0, 2'd3, 32'h0, 64'h0, 0, 0});
      vecs.push_back('{1, 1, 2'd1, 32'h8000_0000, 64'h0, 0, 0});
      vecs.push_back('{0, 1, 2'd0, 32'h1234_5678, 64'h0, 0, 1});
      vecs.push_back('{1, 0, 2'd1, 32'h0, 64'h8000_0101, 0, 1});
      vecs.push_back('{1, 0, 2'd0, 32'h0, 64'h1234_5678, 0, 0});

      bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0; bus.wbs_we_i = 0; bus.wbs_sel_i = 0;
      bus.wbs_adr_i = 0; bus.wbs_dat_i = 0;
      bus.uw_cyc_i = 0; bus.uw_stb_i = 0; bus.uw_we_i = 0; bus.uw_sel_i = 0;
      bus.uw_adr_i = 0; bus.uw_dat_i = 0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("reset stall", bus.uw_stall_o, 1);
      check("reset wbs_ack", bus.wbs_ack_o, 0);
      check("reset wbs_dat", bus.wbs_dat_o, 0);
      check("reset uw_ack", bus.uw_ack_o, 0);
      check("reset uw_dat", bus.uw_dat_o, 0);
      check("reset irqs", {soc_irq, uw_irq}, 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      check("stall after reset", bus.uw_stall_o, 0);

      // Directed table
      for (int i = 0; i < vecs.size(); i++) begin
         do_op(vecs[i].side, vecs[i].we, vecs[i].word, vecs[i].wd, 4'hF, rd, mexp);
         if (!vecs[i].we) check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rd);
         check($sformatf("vec%0d soc_irq", i), soc_irq, vecs[i].exp_soc_irq);
         check($sformatf("vec%0d uw_irq", i), uw_irq, vecs[i].exp_uw_irq);
      end

      // Back-to-back Microwatt pushes 1..8 then 0x99 into a full M2S
      bus.uw_cyc_i = 1; bus.uw_stb_i = 1; bus.uw_we_i = 1; bus.uw_sel_i = 8'hFF;
      bus.uw_adr_i = 32'h0;
      for (int i = 1; i <= 9; i++) begin
         r_wd = (i == 9) ? 32'h99 : 32'(i);
         bus.uw_dat_i = {32'h0, r_wd};
         @(posedge clk); #1;
         check($sformatf("b2b ack %0d", i), bus.uw_ack_o, 1);
         void'(model_xfer(1, 1, 2'd0, r_wd, 4'hF));
      end
      bus.uw_cyc_i = 0; bus.uw_stb_i = 0; bus.uw_we_i = 0;
      @(posedge clk); #1;
      check("b2b ack drop", bus.uw_ack_o, 0);
      do_op(1, 0, 2'd1, 32'h0, 4'hF, rd, mexp);
      check("full status", rd, 64'h8008_000A);
      for (int i = 1; i <= 8; i++) begin
         do_op(0, 0, 2'd0, 32'h0, 4'hF, rd, mexp);
         check($sformatf("drain %0d", i), rd, 64'(i));
      end
      do_op(0, 0, 2'd0, 32'h0, 4'hF, rd, mexp);
      check("drain past end", rd, 64'h0);
      do_op(0, 0, 2'd1, 32'h0, 4'hF, rd, mexp);
      check("soc underflow status", rd, {32'h0, mexp});
      do_op(0, 1, 2'd1, 32'h8000_0004, 4'hF, rd, mexp);
      do_op(1, 1, 2'd1, 32'h8000_0008, 4'hF, rd, mexp);
      do_op(1, 0, 2'd1, 32'h0, 4'hF, rd, mexp);
      check("uw overflow cleared", rd, {32'h0, mexp});

      // M2S holding 3: simultaneous Microwatt push and SoC pop
      for (int i = 10; i <= 12; i++) do_op(1, 1, 2'd0, 32'(i), 4'hF, rd, mexp);
      @(posedge clk); #1;
      bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_we_i = 0; bus.wbs_adr_i = BASE;
      bus.wbs_sel_i = 4'hF;
      bus.uw_cyc_i = 1; bus.uw_stb_i = 1; bus.uw_we_i = 1; bus.uw_adr_i = 32'h0;
      bus.uw_dat_i = 64'd13; bus.uw_sel_i = 8'hFF;
      @(posedge clk); #1;
      check("simul soc ack", bus.wbs_ack_o, 1);
      check("simul soc data", bus.wbs_dat_o, 32'd10);
      check("simul uw ack", bus.uw_ack_o, 1);
      bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0; bus.uw_cyc_i = 0; bus.uw_stb_i = 0;
      bus.uw_we_i = 0;
      void'(model_xfer(0, 0, 2'd0, 32'h0, 4'hF));
      void'(model_xfer(1, 1, 2'd0, 32'd13, 4'hF));
      do_op(1, 0, 2'd1, 32'h0, 4'hF, rd, mexp);
      check("simul count", rd[23:16], 8'd3);
      for (int i = 11; i <= 13; i++) begin
         do_op(0, 0, 2'd0, 32'h0, 4'hF, rd, mexp);
         check($sformatf("simul order %0d", i), rd, 64'(i));
      end

      // Non-hit SoC accesses get no ack and have no side effect
      soc_xfer(1, BASE + 32'h10, 32'hBAD0_0001, 4'hF, srd, acked);
      check("nonhit write ack", acked, 0);
      soc_xfer(0, 32'h2000_0000, 32'h0, 4'hF, srd, acked);
      check("nonhit read ack", acked, 0);
      do_op(1, 0, 2'd1, 32'h0, 4'hF, rd, mexp);
      check("nonhit no push", rd, {32'h0, mexp});

      // Random traffic against the model
      for (int n = 0; n < 240; n++) begin
         r_side = 1'($urandom_range(0, 1));
         r_we   = (n < 120) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 3);
         r_word = ($urandom_range(0, 19) < 14) ? 2'd0 :
                  ($urandom_range(0, 4) != 0) ? 2'd1 : 2'($urandom_range(2, 3));
         r_wd   = $urandom;
         r_sel  = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
         do_op(r_side, r_we, r_word, r_wd, r_sel, rd, mexp);
         if (!r_we) check($sformatf("rnd%0d rdata", n), rd, {32'h0, mexp});
         check($sformatf("rnd%0d soc_irq", n), soc_irq, exp_soc_irq());
         check($sformatf("rnd%0d uw_irq", n), uw_irq, exp_uw_irq());
      end

      // Reset dropped while a SoC read is waiting for its ack
      do_op(1, 1, 2'd0, 32'h77, 4'hF, rd, mexp);
      do_op(0, 1, 2'd0, 32'h88, 4'hF, rd, mexp);
      @(posedge clk); #1;
      bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_we_i = 0; bus.wbs_adr_i = BASE;
      #2 rst_n = 1'b0;
      #1;
      check("rst stall", bus.uw_stall_o, 1);
      acked = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         if (bus.wbs_ack_o) acked = 1'b1;
      end
      check("rst ack dropped", acked, 0);
      check("rst irqs", {soc_irq, uw_irq}, 0);
      bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0;
      m2s_q.delete();
      s2m_q.delete();
      unf = '{0, 0}; ovf = '{0, 0}; ien = '{0, 0};
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      check("post rst stall", bus.uw_stall_o, 0);
      do_op(0, 0, 2'd1, 32'h0, 4'hF, rd, mexp);
      check("post rst soc status", rd, 64'h0);
      do_op(1, 0, 2'd1, 32'h0, 4'hF, rd, mexp);
      check("post rst uw status", rd, 64'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
